fpu_dp_sequencer: RTL and testbench

Request front-end and result collector for the double-precision FPU core. It accepts operand/opcode requests over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It drives one operation at a time into the free-running, register-output FPU core, holds operands stable for the core's evaluation edge, and captures the core's result and flags. It then presents each result downstream with a valid/ready handshake, in request order, carrying the requester's tag.

---
 rtl/fpu_dp_sequencer_if.sv | 31 +++
 rtl/fpu_dp_sequencer.sv | 145 ++++++++++++++
 tb/tb_fpu_dp_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_dp_sequencer_if.sv
// Request/result handshake bundle between a requester/consumer and fpu_dp_sequencer.
// The master side issues requests and accepts results; the slave side is the sequencer.
interface fpu_dp_sequencer_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_opcode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_overflow;
  logic             out_underflow;
  logic             out_nan;

  modport master (
    output in_valid, in_a, in_b, in_opcode, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_overflow, out_underflow, out_nan
  );

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_overflow, out_underflow, out_nan
  );
endinterface

// File: rtl/fpu_dp_sequencer.sv
// Request FIFO plus one-op-at-a-time launcher and result collector for the
// register-output double-precision FPU core; results leave in request order.
module fpu_dp_sequencer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fpu_dp_sequencer_if.slave      bus,
  output logic [WIDTH-1:0]       fpu_a,
  output logic [WIDTH-1:0]       fpu_b,
  output logic [1:0]             fpu_opcode,
  input  logic [WIDTH-1:0]       fpu_result,
  input  logic                   fpu_overflow,
  input  logic                   fpu_underflow,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * WIDTH + 2 + TAG_W;
  localparam int OP_LSB  = TAG_W;
  localparam int B_LSB   = TAG_W + 2;
  localparam int A_LSB   = TAG_W + 2 + WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    CAPTURE,
    OUTPUT
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               push;
  logic               pop;
  logic [TAG_W-1:0]   flight_tag;

  // in_ready looks only at the registered count, never at a same-cycle pop
  assign bus.in_ready = (count < (PTR_W + 1)'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem[rd_ptr];
  assign occupancy    = count;
  assign busy         = (state != IDLE) || (count != '0);
  assign bus.out_nan  = (bus.out_result[62:52] == 11'h7FF) && (bus.out_result[51:0] != 52'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = OUTPUT;
      OUTPUT: begin
        if (bus.out_ready) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = LAUNCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_opcode, bus.in_tag};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_opcode <= 2'b00;
      flight_tag <= '0;
    end else if (pop) begin
      fpu_a      <= head[A_LSB +: WIDTH];
      fpu_b      <= head[B_LSB +: WIDTH];
      fpu_opcode <= head[OP_LSB +: 2];
      flight_tag <= head[TAG_W-1:0];
    end
  end

  // The core output register already holds the launched op's result in CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid     <= 1'b0;
      bus.out_result    <= '0;
      bus.out_tag       <= '0;
      bus.out_overflow  <= 1'b0;
      bus.out_underflow <= 1'b0;
    end else if (state == CAPTURE) begin
      bus.out_valid     <= 1'b1;
      bus.out_result    <= fpu_result;
      bus.out_tag       <= flight_tag;
      bus.out_overflow  <= fpu_overflow;
      bus.out_underflow <= fpu_underflow;
    end else if ((state == OUTPUT) && bus.out_ready) begin
      bus.out_valid     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fpu_dp_sequencer.sv
// Self-checking bench for fpu_dp_sequencer: behavioural FPU core, scoreboard of
// expected results in push order, directed cases plus randomized traffic.
`timescale 1ns/1ps
module tb_fpu_dp_sequencer;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] res;
    logic [3:0]  tag;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [WIDTH-1:0]       fpu_a;
  logic [WIDTH-1:0]       fpu_b;
  logic [1:0]             fpu_opcode;
  logic [WIDTH-1:0]       fpu_result = '0;
  logic                   fpu_overflow = 1'b0;
  logic                   fpu_underflow = 1'b0;
  logic                   busy;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   ready_ctrl = 1'b0;
  logic                   rand_ready = 1'b0;
  logic                   rand_bit = 1'b0;
  logic                   prev_valid = 1'b0;
  int                     cycle = 0;
  int                     n_tests = 0;
  int                     n_fail = 0;
  exp_t                   sb[$];

  fpu_dp_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  fpu_dp_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .fpu_a        (fpu_a),
    .fpu_b        (fpu_b),
    .fpu_opcode   (fpu_opcode),
    .fpu_result   (fpu_result),
    .fpu_overflow (fpu_overflow),
    .fpu_underflow(fpu_underflow),
    .busy         (busy),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(posedge clk) rand_bit <= 1'($urandom_range(0, 1));

  assign bus.out_ready = rand_ready ? rand_bit : ready_ctrl;

  // Behavioural IEEE-754 double core: result and flags straight from real arithmetic
  function automatic logic [65:0] core_eval(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] op);
    real         ra;
    real         rb;
    real         rr;
    logic [63:0] r;
    logic        ovf;
    logic        unf;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    case (op)
      2'b00:   rr = ra + rb;
      2'b01:   rr = ra - rb;
      2'b10:   rr = ra * rb;
      default: rr = ra / rb;
    endcase
    r   = $realtobits(rr);
    ovf = (r[62:52] == 11'h7FF) && (a[62:52] != 11'h7FF) && (b[62:52] != 11'h7FF);
    unf = (r[62:52] == 11'h000) && op[1] && (a[62:0] != 63'd0) && (b[62:0] != 63'd0);
    return {ovf, unf, r};
  endfunction

  always @(posedge clk) {fpu_overflow, fpu_underflow, fpu_result} <= core_eval(fpu_a, fpu_b, fpu_opcode);

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, obs, exp);
    end
  endtask

  // Result monitor: every handshake must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    logic exp_nan;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (sb.size() == 0) checkOutput("out_valid_unexpected", 64'(bus.out_valid), 64'd0);
        else checkOutput("fpu_a_hold", fpu_a, sb[0].a);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("result_unexpected", 64'(bus.out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          exp_nan = (e.res[62:52] == 11'h7FF) && (e.res[51:0] != 52'd0);
          checkOutput("out_result", bus.out_result, e.res);
          checkOutput("out_tag", 64'(bus.out_tag), 64'(e.tag));
          checkOutput("out_overflow", 64'(bus.out_overflow), 64'(e.ovf));
          checkOutput("out_underflow", 64'(bus.out_underflow), 64'(e.unf));
          checkOutput("out_nan", 64'(bus.out_nan), 64'(exp_nan));
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                               input logic [3:0] tag, input logic [65:0] expv, output int acc);
    int waited;
    exp_t e;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_opcode = op;
    bus.in_tag    = tag;
    waited = 0;
    acc = cycle;
    while (!bus.in_ready && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      @(posedge clk);
      e.a   = a;
      e.res = expv[63:0];
      e.unf = expv[64];
      e.ovf = expv[65];
      e.tag = tag;
      sb.push_back(e);
      #1;
      acc = cycle;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pushModel(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                           input logic [3:0] tag);
    int acc;
    applyStimulus(a, b, op, tag, core_eval(a, b, op), acc);
  endtask

  task automatic waitValid(output int when);
    int n;
    n = 0;
    when = cycle;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) checkOutput("valid_timeout", 64'(bus.out_valid), 64'd1);
    when = cycle;
  endtask

  task automatic drain();
    int n;
    ready_ctrl = 1'b1;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", 64'(sb.size()), 64'd0);
    checkOutput("drain_busy", 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 9))
      0:       return $realtobits(1.0e300);
      1:       return $realtobits(1.0e-300);
      default: return $realtobits(real'($urandom_range(0, 4000)) / 16.0 - 125.0);
    endcase
  endfunction

  initial begin
    int acc;
    int when;
    logic [63:0] held;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_opcode = 2'b00;
    bus.in_tag    = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_result", bus.out_result, 64'd0);
    checkOutput("rst_out_tag", 64'(bus.out_tag), 64'd0);
    checkOutput("rst_flags", 64'({bus.out_overflow, bus.out_underflow, bus.out_nan}), 64'd0);
    checkOutput("rst_fpu_a", fpu_a, 64'd0);
    checkOutput("rst_fpu_b", fpu_b, 64'd0);
    checkOutput("rst_fpu_opcode", 64'(fpu_opcode), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD: out_valid three edges after the accept edge
    ready_ctrl = 1'b1;
    applyStimulus(64'h3FF0000000000000, 64'h4000000000000000, 2'b00, 4'd3,
                  {2'b00, 64'h4008000000000000}, acc);
    waitValid(when);
    checkOutput("add_latency", 64'(when - acc), 64'd3);
    checkOutput("add_result", bus.out_result, 64'h4008000000000000);
    checkOutput("add_tag", 64'(bus.out_tag), 64'd3);
    drain();

    // Backpressure: one in flight plus four queued, sixth request refused
    ready_ctrl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pushModel($realtobits(real'(i + 1)), $realtobits(0.5), 2'b00, 4'(i));
    end
    bus.in_valid  = 1'b1;
    bus.in_a      = $realtobits(9.0);
    bus.in_b      = $realtobits(9.0);
    bus.in_opcode = 2'b10;
    bus.in_tag    = 4'd5;
    held = bus.out_result;
    for (int i = 0; i < 4; i++) begin
      checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("full_occupancy", 64'(occupancy), 64'd4);
      checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("hold_result", bus.out_result, held);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();

    // Mixed operations with known exact results
    applyStimulus($realtobits(3.0), $realtobits(1.0), 2'b01, 4'd7, {2'b00, 64'h4000000000000000}, acc);
    applyStimulus($realtobits(2.0), $realtobits(3.0), 2'b10, 4'd8, {2'b00, 64'h4018000000000000}, acc);
    applyStimulus($realtobits(1.0), $realtobits(2.0), 2'b11, 4'd9, {2'b00, 64'h3FE0000000000000}, acc);
    drain();

    // +INF + -INF gives NaN, then an ordinary sum clears out_nan
    pushModel(64'h7FF0000000000000, 64'hFFF0000000000000, 2'b00, 4'd10);
    waitValid(when);
    checkOutput("inf_nan", 64'(bus.out_nan), 64'd1);
    drain();
    applyStimulus($realtobits(1.0), $realtobits(1.0), 2'b00, 4'd11, {2'b00, 64'h4000000000000000}, acc);
    waitValid(when);
    checkOutput("after_nan", 64'(bus.out_nan), 64'd0);
    drain();

    // Push with simultaneous pop at count DEPTH-1
    ready_ctrl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pushModel($realtobits(real'(i)), $realtobits(2.0), 2'b10, 4'(i + 12));
    end
    checkOutput("cnt3_before", 64'(occupancy), 64'd3);
    checkOutput("cnt3_valid", 64'(bus.out_valid), 64'd1);
    ready_ctrl = 1'b1;
    pushModel($realtobits(7.0), $realtobits(2.0), 2'b01, 4'd0);
    checkOutput("cnt3_after", 64'(occupancy), 64'd3);
    drain();

    // Pointer wrap with ten sequential requests
    for (int i = 0; i < 10; i++) begin
      pushModel($realtobits(real'(i) * 1.5), $realtobits(0.25), 2'(i), 4'(i));
    end
    drain();

    // Reset during CAPTURE with two entries queued
    ready_ctrl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pushModel($realtobits(real'(i + 4)), $realtobits(1.0), 2'b00, 4'(i + 1));
    end
    checkOutput("mid_occupancy", 64'(occupancy), 64'd2);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_occ", 64'(occupancy), 64'd0);
    checkOutput("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ready_ctrl = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("no_stale_valid", 64'(bus.out_valid), 64'd0);
    end
    applyStimulus($realtobits(2.5), $realtobits(2.0), 2'b10, 4'd6, {2'b00, 64'h4014000000000000}, acc);
    drain();

    // Randomized traffic with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pushModel(rand_operand(), rand_operand(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
